prog_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the CPU top level. It accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes them sequentially into instruction memory through a dedicated write port, holding the CPU in reset until the image is loaded. On success it releases `cpu_rst`; on a malformed image it parks in a sticky error state with the CPU still held.

---
 rtl/prog_loader_pkg.sv | 20 ++
 rtl/prog_loader_csum.sv | 25 ++
 rtl/prog_loader.sv | 126 ++++++++++++
 tb/tb_prog_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the boot program loader
// PROG_LOADER_CSUM_EN adds the trailing checksum state.
package prog_loader_pkg;

  localparam int BYTE_WIDTH = 8;
  localparam int HDR_BYTES  = 2;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DAT_HI,
    DAT_LO,
`ifdef PROG_LOADER_CSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/prog_loader_csum.sv
// rtl/prog_loader_csum.sv - 8-bit modular running sum of stream bytes
// Only instantiated when PROG_LOADER_CSUM_EN is defined.
module prog_loader_csum
  import prog_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  add,
  input  logic [BYTE_WIDTH-1:0] data,
  output logic                  match
);

  logic [BYTE_WIDTH-1:0] sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + data;
    end
  end

  assign match = (sum == data);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader: byte stream to instruction memory, holds CPU in reset
// Optional trailing checksum byte enabled by PROG_LOADER_CSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int INST_ADDR_WIDTH     = 16,
  parameter int INST_DATA_BIT_WIDTH = 16,
  parameter int INST_MEM_SIZE       = 26,
  parameter int NUM_BYTES_IN_INST   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [BYTE_WIDTH-1:0]          in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           mem_we,
  output logic [INST_ADDR_WIDTH-1:0]     mem_addr,
  output logic [INST_DATA_BIT_WIDTH-1:0] mem_data,
  output logic                           cpu_rst,
  output logic                           done,
  output logic                           error
);

  localparam int CNT_WIDTH = HDR_BYTES * BYTE_WIDTH;

  state_t                     state;
  state_t                     fin_state;
  logic [BYTE_WIDTH-1:0]      len_hi;
  logic [BYTE_WIDTH-1:0]      dat_hi;
  logic [CNT_WIDTH-1:0]       word_cnt;
  logic [CNT_WIDTH-1:0]       len_next;
  logic [INST_ADDR_WIDTH-1:0] idx;
  logic [INST_ADDR_WIDTH-1:0] idx_inc;
  logic                       xfer;

  assign in_ready = !rst && (state != DONE) && (state != ERR);
  assign xfer     = in_valid && in_ready;
  assign len_next = {len_hi, in_data};
  assign idx_inc  = idx + 1'b1;

`ifdef PROG_LOADER_CSUM_EN
  logic csum_match;

  // The checksum byte itself is compared, never accumulated.
  prog_loader_csum u_csum (
    .clk   (clk),
    .rst   (rst),
    .add   (xfer && (state != CSUM)),
    .data  (in_data),
    .match (csum_match)
  );

  assign fin_state = CSUM;
`else
  assign fin_state = DONE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LEN_HI;
      len_hi   <= '0;
      dat_hi   <= '0;
      word_cnt <= '0;
      idx      <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      // Release trails done by one cycle so the final write lands first.
      cpu_rst <= !done;
      if (xfer) begin
        case (state)
          LEN_HI: begin
            len_hi <= in_data;
            state  <= LEN_LO;
          end
          LEN_LO: begin
            word_cnt <= len_next;
            if (len_next > CNT_WIDTH'(INST_MEM_SIZE)) begin
              state <= ERR;
              error <= 1'b1;
            end else if (len_next == '0) begin
              state <= fin_state;
              if (fin_state == DONE) done <= 1'b1;
            end else begin
              state <= DAT_HI;
            end
          end
          DAT_HI: begin
            dat_hi <= in_data;
            state  <= DAT_LO;
          end
          DAT_LO: begin
            mem_we   <= 1'b1;
            mem_addr <= INST_ADDR_WIDTH'(idx * INST_ADDR_WIDTH'(NUM_BYTES_IN_INST));
            mem_data <= INST_DATA_BIT_WIDTH'({dat_hi, in_data});
            idx      <= idx_inc;
            if (idx_inc == INST_ADDR_WIDTH'(word_cnt)) begin
              state <= fin_state;
              if (fin_state == DONE) done <= 1'b1;
            end else begin
              state <= DAT_HI;
            end
          end
`ifdef PROG_LOADER_CSUM_EN
          CSUM: begin
            if (csum_match) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
`endif
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

`ifdef PROG_LOADER_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = -1;
  int rel_cyc = -1;
  int err_cyc = -1;
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int          wr_cyc[$];
  logic [7:0]  stim[$];

  prog_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_data);
      wr_cyc.push_back(cyc);
    end
    if (done && done_cyc < 0) done_cyc = cyc;
    if (error && err_cyc < 0) err_cyc = cyc;
    if (!cpu_rst && rel_cyc < 0) rel_cyc = cyc;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    done_cyc = -1; rel_cyc = -1; err_cyc = -1;
    rst = 1'b0;
  endtask

  task automatic add_csum();
    logic [7:0] s;
    s = 8'h00;
    foreach (stim[k]) s = s + stim[k];
    if (CS != 0) stim.push_back(s);
  endtask

  task automatic drive(input bit toggle);
    int i;
    int budget;
    int limit;
    bit ph;
    i = 0; ph = 1'b0;
    limit = 4 * stim.size() + 20;
    budget = limit;
    while (i < stim.size() && budget > 0) begin
      @(negedge clk);
      if (budget == limit) start_cyc = cyc;
      budget--;
      if (toggle && ph) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data = stim[i];
      end
      ph = !ph;
      #1;
      if (in_valid && in_ready) i++;
    end
    checks++;
    if (i !== stim.size()) begin
      failures++;
      $display("FAIL drive_timeout accepted=%0d required=%0d", i, stim.size());
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
    do_reset();
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%0b exp=0", mem_we); end
    checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
    checks++; if (mem_data !== 16'h0) begin failures++; $display("FAIL rst_mem_data got=%0h exp=0", mem_data); end
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL rst_cpu_rst got=%0b exp=1", cpu_rst); end
    checks++; if (done !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL rst_flags got=%0b%0b exp=00", done, error); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%0b exp=1", in_ready); end
  endtask

  task automatic test_two_words();
    do_reset();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    add_csum();
    drive(1'b0);
    checks++; if (wr_cyc.size() !== 2) begin failures++; $display("FAIL tw_count got=%0d exp=2", wr_cyc.size()); end
    if (wr_cyc.size() == 2) begin
      checks++; if (wr_addr[0] !== 16'h0 || wr_data[0] !== 16'h1234) begin failures++; $display("FAIL tw_w0 got=%0h@%0h exp=1234@0", wr_data[0], wr_addr[0]); end
      checks++; if (wr_addr[1] !== 16'h2 || wr_data[1] !== 16'hABCD) begin failures++; $display("FAIL tw_w1 got=%0h@%0h exp=abcd@2", wr_data[1], wr_addr[1]); end
      checks++; if (wr_cyc[0] !== start_cyc + 4) begin failures++; $display("FAIL tw_lat0 got=%0d exp=%0d", wr_cyc[0], start_cyc + 4); end
      checks++; if (wr_cyc[1] - wr_cyc[0] !== 2) begin failures++; $display("FAIL tw_gap got=%0d exp=2", wr_cyc[1] - wr_cyc[0]); end
      checks++; if (done_cyc !== wr_cyc[1] + CS) begin failures++; $display("FAIL tw_done_cyc got=%0d exp=%0d", done_cyc, wr_cyc[1] + CS); end
      checks++; if (rel_cyc !== wr_cyc[1] + 1 + CS) begin failures++; $display("FAIL tw_release got=%0d exp=%0d", rel_cyc, wr_cyc[1] + 1 + CS); end
    end
    checks++; if (done !== 1'b1 || error !== 1'b0 || cpu_rst !== 1'b0) begin failures++; $display("FAIL tw_final got=d%0b e%0b c%0b exp=d1 e0 c0", done, error, cpu_rst); end
    checks++; if (mem_addr !== 16'h2 || mem_data !== 16'hABCD) begin failures++; $display("FAIL tw_hold got=%0h@%0h exp=abcd@2", mem_data, mem_addr); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL tw_ready_done got=%0b exp=0", in_ready); end
  endtask

  task automatic test_too_long();
    do_reset();
    stim = '{8'h00, 8'h1B};
    drive(1'b0);
    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err_cyc !== start_cyc + 2) begin failures++; $display("FAIL tl_err_cyc got=%0d exp=%0d", err_cyc, start_cyc + 2); end
    checks++; if (error !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL tl_flags got=e%0b d%0b exp=e1 d0", error, done); end
    checks++; if (cpu_rst !== 1'b1) begin failures++; $display("FAIL tl_cpu_rst got=%0b exp=1", cpu_rst); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL tl_ready got=%0b exp=0", in_ready); end
    checks++; if (wr_cyc.size() !== 0) begin failures++; $display("FAIL tl_writes got=%0d exp=0", wr_cyc.size()); end
    in_valid = 1'b0;
  endtask

  task automatic test_max_words();
    do_reset();
    stim = '{8'h00, 8'h1A};
    for (int w = 0; w < 26; w++) begin
      stim.push_back(8'(w + 1));
      stim.push_back(8'(8'hF0 - w));
    end
    add_csum();
    drive(1'b0);
    checks++; if (wr_cyc.size() !== 26) begin failures++; $display("FAIL mx_count got=%0d exp=26", wr_cyc.size()); end
    for (int w = 0; w < 26 && w < wr_cyc.size(); w++) begin
      checks++;
      if (wr_addr[w] !== 16'(2 * w) || wr_data[w] !== {8'(w + 1), 8'(8'hF0 - w)}) begin
        failures++;
        $display("FAIL mx_word%0d got=%0h@%0h exp=%0h@%0h", w, wr_data[w], wr_addr[w], {8'(w + 1), 8'(8'hF0 - w)}, 2 * w);
      end
    end
    checks++; if (done !== 1'b1 || error !== 1'b0 || cpu_rst !== 1'b0) begin failures++; $display("FAIL mx_final got=d%0b e%0b c%0b exp=d1 e0 c0", done, error, cpu_rst); end
  endtask

  task automatic test_zero_words();
    do_reset();
    stim = '{8'h00, 8'h00};
    add_csum();
    drive(1'b0);
    checks++; if (wr_cyc.size() !== 0) begin failures++; $display("FAIL zw_writes got=%0d exp=0", wr_cyc.size()); end
    checks++; if (done_cyc !== start_cyc + 2 + CS) begin failures++; $display("FAIL zw_done_cyc got=%0d exp=%0d", done_cyc, start_cyc + 2 + CS); end
    checks++; if (done !== 1'b1 || cpu_rst !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL zw_final got=d%0b c%0b e%0b exp=d1 c0 e0", done, cpu_rst, error); end
  endtask

  task automatic test_stall();
    do_reset();
    stim = '{8'h00, 8'h01, 8'h12, 8'h34};
    add_csum();
    drive(1'b1);
    checks++; if (wr_cyc.size() !== 1) begin failures++; $display("FAIL st_count got=%0d exp=1", wr_cyc.size()); end
    if (wr_cyc.size() == 1) begin
      checks++; if (wr_addr[0] !== 16'h0 || wr_data[0] !== 16'h1234) begin failures++; $display("FAIL st_w0 got=%0h@%0h exp=1234@0", wr_data[0], wr_addr[0]); end
    end
    checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin failures++; $display("FAIL st_final got=d%0b c%0b exp=d1 c0", done, cpu_rst); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    drive(1'b0);
    do_reset();
    #1;
    checks++; if (mem_addr !== 16'h0 || mem_data !== 16'h0 || done !== 1'b0) begin failures++; $display("FAIL rm_cleared got=%0h@%0h d%0b exp=0@0 d0", mem_data, mem_addr, done); end
    stim = '{8'h00, 8'h01, 8'h55, 8'h66};
    add_csum();
    drive(1'b0);
    checks++; if (wr_cyc.size() !== 1) begin failures++; $display("FAIL rm_count got=%0d exp=1", wr_cyc.size()); end
    if (wr_cyc.size() == 1) begin
      checks++; if (wr_addr[0] !== 16'h0 || wr_data[0] !== 16'h5566) begin failures++; $display("FAIL rm_w0 got=%0h@%0h exp=5566@0", wr_data[0], wr_addr[0]); end
    end
    checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin failures++; $display("FAIL rm_final got=d%0b c%0b exp=d1 c0", done, cpu_rst); end
  endtask

`ifdef PROG_LOADER_CSUM_EN
  task automatic test_bad_csum();
    do_reset();
    stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    drive(1'b0);
    checks++; if (wr_cyc.size() !== 1) begin failures++; $display("FAIL bc_count got=%0d exp=1", wr_cyc.size()); end
    checks++; if (error !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1) begin failures++; $display("FAIL bc_final got=e%0b d%0b c%0b exp=e1 d0 c1", error, done, cpu_rst); end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_too_long();
    test_max_words();
    test_zero_words();
    test_stall();
    test_reset_mid();
`ifdef PROG_LOADER_CSUM_EN
    test_bad_csum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
